// File: rtl/sqm_pkg.sv
// Shared types for the sqm result path: one {c,y} result pair per entry.
package sqm_pkg;
  localparam int SQM_RES_W = 16;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] y;
  } sqm_res_t;
endpackage

// File: rtl/sqm_fifo_mem.sv
// DEPTH x sqm_res_t register array with one write port and an async read port.
module sqm_fifo_mem
  import sqm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sqm_res_t      wdata,
  input  logic [AW-1:0] raddr,
  output sqm_res_t      rdata
);

  // No reset on the storage; the top masks the read data while empty.
  sqm_res_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sqm_result_fifo.sv
// Buffers sqm {c,y} results in a small FIFO toward a stallable consumer and
// keeps a saturating count of accepted results.
module sqm_result_fifo
  import sqm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_c,
  input  logic [7:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_c,
  output logic [7:0]       out_y,
  output logic [CW-1:0]    count,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             push, pop;
  sqm_res_t         wdata, rdata;

  // Full is judged on registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wdata.c = in_c;
  assign wdata.y = in_y;

  sqm_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (push && (acc_cnt_q != '1)) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign out_c   = out_valid ? rdata.c : 8'h00;
  assign out_y   = out_valid ? rdata.y : 8'h00;
  assign count   = count_q;
  assign acc_cnt = acc_cnt_q;

endmodule

// File: tb/tb_sqm_result_fifo.sv
// Bench for sqm_result_fifo: directed table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sqm_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int ACC_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_c;
  logic [7:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_c;
  logic [7:0]       out_y;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] acc_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  int          acc_m = 0;

  typedef struct {
    logic       iv;
    logic [7:0] c;
    logic [7:0] y;
    logic       ro;
    int         cnt;
    logic       ov;
    logic       ir;
    logic [7:0] oc;
    logic [7:0] oy;
    int         acc;
  } vec_t;

  vec_t vecs[12];

  sqm_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_y     (out_y),
    .count     (count),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] head;
    head = (q.size() != 0) ? q[0] : 16'h0000;
    chk({tag, " count"},     32'(count),     32'(q.size()));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, " in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
    chk({tag, " out_c"},     32'(out_c),     32'(head[15:8]));
    chk({tag, " out_y"},     32'(out_y),     32'(head[7:0]));
    chk({tag, " acc_cnt"},   32'(acc_cnt),   32'(acc_m));
  endtask

  // One clock with the given inputs; the model applies the same handshake rules.
  task automatic cycle(input logic fl, input logic iv, input logic [7:0] c,
                       input logic [7:0] y, input logic ro, input string tag);
    bit mp, mo;
    flush = fl; in_valid = iv; in_c = c; in_y = y; out_ready = ro;
    mp = iv && (q.size() != DEPTH);
    mo = ro && (q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (mo) void'(q.pop_front());
      if (mp) begin
        q.push_back({c, y});
        if (acc_m != ACC_MAX) acc_m++;
      end
    end
    check_model(tag);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'h00, 8'h00, 0};
    vecs[1]  = '{1'b1, 8'h2A, 8'h13, 1'b0, 1, 1'b1, 1'b1, 8'h2A, 8'h13, 1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 8'h00, 1};
    vecs[3]  = '{1'b1, 8'h01, 8'h10, 1'b0, 1, 1'b1, 1'b1, 8'h01, 8'h10, 2};
    vecs[4]  = '{1'b1, 8'h02, 8'h20, 1'b0, 2, 1'b1, 1'b1, 8'h01, 8'h10, 3};
    vecs[5]  = '{1'b1, 8'h03, 8'h30, 1'b0, 3, 1'b1, 1'b1, 8'h01, 8'h10, 4};
    vecs[6]  = '{1'b1, 8'h04, 8'h40, 1'b0, 4, 1'b1, 1'b0, 8'h01, 8'h10, 5};
    vecs[7]  = '{1'b1, 8'h05, 8'h50, 1'b0, 4, 1'b1, 1'b0, 8'h01, 8'h10, 5};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h02, 8'h20, 5};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h03, 8'h30, 5};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h04, 8'h40, 5};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 8'h00, 5};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_c = 8'h00; in_y = 8'h00;
    #12;
    chk("reset count",     32'(count),     0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready",  32'(in_ready),  1);
    chk("reset acc_cnt",   32'(acc_cnt),   0);
    chk("reset out_c",     32'(out_c),     0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      flush = 1'b0; in_valid = vecs[i].iv; in_c = vecs[i].c; in_y = vecs[i].y;
      out_ready = vecs[i].ro;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].cnt));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
      chk($sformatf("vec%0d out_c", i),     32'(out_c),     32'(vecs[i].oc));
      chk($sformatf("vec%0d out_y", i),     32'(out_y),     32'(vecs[i].oy));
      chk($sformatf("vec%0d acc_cnt", i),   32'(acc_cnt),   32'(vecs[i].acc));
    end
    q.delete();
    acc_m = 5;

    // Full FIFO with simultaneous push attempt and pop: only the pop happens.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b1, 8'(8'h11 + i), 8'(8'hA0 + i), 1'b0, "fill");
    cycle(1'b0, 1'b1, 8'h77, 8'h77, 1'b1, "full_pop");
    chk("full_pop count", 32'(count), 3);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 8'(8'h50 + i), 8'(8'hC0 + i), 1'b1, "stream");
    chk("stream count", 32'(count), 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "drain");

    // Flush with a concurrent push: AA is dropped and not counted.
    cycle(1'b0, 1'b1, 8'h31, 8'h32, 1'b0, "pre_flush");
    cycle(1'b0, 1'b1, 8'h33, 8'h34, 1'b0, "pre_flush");
    cycle(1'b1, 1'b1, 8'hAA, 8'hBB, 1'b1, "flush");
    chk("flush out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "post_flush");

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 8'(8'h61 + i), 8'(8'h71 + i), 1'b0, "pre_rst");
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst out_valid", 32'(out_valid), 0);
    chk("async_rst count",     32'(count),     0);
    chk("async_rst out_c",     32'(out_c),     0);
    chk("async_rst acc_cnt",   32'(acc_cnt),   0);
    q.delete();
    acc_m = 0;
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "post_rst");
    cycle(1'b0, 1'b1, 8'h9C, 8'h9D, 1'b0, "post_rst_push");

    // Randomized traffic, long enough to saturate the accept counter.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(15) == 0), 1'($urandom_range(1)), 8'($urandom),
            8'($urandom), 1'($urandom_range(1)), "rand");
    chk("acc saturated", 32'(acc_cnt), ACC_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
